// File: rtl/polynomial3_source_if.sv
// Polynomial3 message type and its valid/ready channel.
// Shared by every Polynomial3 producer and consumer.
package poly3_pkg;

  localparam int A_W = 24;
  localparam int B_W = 16;
  localparam int C_W = 8;

  typedef struct packed {
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    logic [C_W-1:0] c;
  } poly3_t;

endpackage

interface IPolynomial3ValidReady;
  import poly3_pkg::*;

  logic   valid;
  logic   ready;
  poly3_t data;

  modport Source (
    output valid,
    output data,
    input  ready
  );

  modport Sink (
    input  valid,
    input  data,
    output ready
  );

endinterface

// File: rtl/polynomial3_source.sv
// Polynomial3 producer: staged register writes, commit FIFO, valid/ready out.
// Optional handshake counter port `sent` under POLY3_SOURCE_STATS_EN.
module polynomial3_source
  import poly3_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [1:0]           wr_addr,
  input  logic [31:0]          wr_data,
  IPolynomial3ValidReady.Source abc,
  output logic [CNT_W-1:0]     count,
  output logic                 full,
  output logic                 overflow
`ifdef POLY3_SOURCE_STATS_EN
  ,
  output logic [15:0]          sent
`endif
);

  localparam int AW = $clog2(DEPTH);

  poly3_t         mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic [A_W-1:0] sa;
  logic [B_W-1:0] sb;
  logic [C_W-1:0] sc;

  logic commit;
  logic push;
  logic pop;
  logic unused_wr;

  assign unused_wr = ^wr_data[31:A_W];

  assign commit = wr_en && (wr_addr == 2'd3);
  assign pop    = abc.valid && abc.ready;
  assign push   = commit && (!full || pop);

  // Outputs come from registered occupancy only, never from ready or wr_*.
  assign full      = (count == CNT_W'(DEPTH));
  assign abc.valid = (count != '0);
  assign abc.data  = mem[rd_ptr];

  // Staging registers hold the next triple; commit leaves them intact.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa <= '0;
      sb <= '0;
      sc <= '0;
    end else if (wr_en) begin
      unique case (wr_addr)
        2'd0:    sa <= wr_data[A_W-1:0];
        2'd1:    sb <= wr_data[B_W-1:0];
        2'd2:    sc <= wr_data[C_W-1:0];
        default: ;
      endcase
    end
  end

  // FIFO storage; contents are don't-care when not occupied.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{a: sa, b: sb, c: sc};
    end
  end

  // Circular pointers wrap naturally at power-of-two DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Occupancy tracks push/pop; simultaneous push and pop cancel.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky flag for a commit that found no room.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (commit && !push) begin
      overflow <= 1'b1;
    end
  end

`ifdef POLY3_SOURCE_STATS_EN
  // Completed handshakes, wrapping at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      sent <= '0;
    end else if (pop) begin
      sent <= sent + 16'd1;
    end
  end
`endif

endmodule

// File: doc/polynomial3_source.md
# polynomial3_source

Producer end of the `IPolynomial3ValidReady` channel: drives Polynomial3 coefficient messages into consumers such as the polynomial compute block. A legacy register-write port stages fields `a`, `b`, `c`; a commit write pushes the staged triple into a small FIFO. The FIFO drains onto the ESI valid/ready channel. Sits between host/CSR logic and any Polynomial3 sink.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO entries; power of two, ≥2.
- `CNT_W`, default `$clog2(DEPTH+1)`: width of `count`.

Ports:
- `clk`  in  1  sole clock, all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `wr_en`  in  1  legacy register write strobe.
- `wr_addr`  in  2  0=a, 1=b, 2=c, 3=commit.
- `wr_data`  in  32  write data; LSBs truncated to field width; ignored for commit.
- `abc`  `IPolynomial3ValidReady.Source`  -  ESI channel out. Block drives `valid` and `data`; sink drives `ready`.
- `count`  out  CNT_W  messages currently queued.
- `full`  out  1  `count == DEPTH`.
- `overflow`  out  1  sticky: a commit was dropped.
- `sent`  out  16  only with `POLY3_SOURCE_STATS_EN`; see Configuration.

## Operation
- Staging registers `sa`, `sb`, `sc` are written at addr 0/1/2 when `wr_en`. Each takes `wr_data` truncated to its Polynomial3 field width.
- Staging registers keep their value after a commit, so repeated commits resend the same triple.
- Commit (`wr_en && wr_addr==3`) pushes `{sa,sb,sc}` into the FIFO.
  - The pushed values are the staging values before this edge.
  - A commit is accepted if `!full`, or if a pop occurs in the same cycle.
- Commit while full and no pop: the message is dropped, FIFO is unchanged, and `overflow` is set to 1.
  - `overflow` clears only on `rst`.
- `abc.valid` = FIFO non-empty. `abc.data` = FIFO head.
- Pop happens when `abc.valid && abc.ready` at a rising edge.
- The FIFO is circular, with read and write pointers wrapping modulo DEPTH.
- `count` changes by +1 on push only, by −1 on pop only, and is unchanged on push and pop together.

## Timing
- Reset values: `abc.valid`=0, `count`=0, `full`=0, `overflow`=0, staging registers=0, pointers=0, `sent`=0.
- `abc.data` is don't-care while `abc.valid`=0.
- Latency: a commit at edge N makes `abc.valid`=1 in cycle N+1 if the FIFO was empty. There is no combinational path from `wr_*` to `abc`.
- Handshake rules:
  - Once `valid` is asserted, `valid` and `data` stay stable until the cycle in which `ready`=1.
  - `valid` never depends combinationally on `ready`.
  - `ready` may toggle freely.
- Full throughput: one commit and one pop per cycle sustain indefinitely at any occupancy.
- Empty FIFO with a same-cycle commit: no pop occurs, because `valid` was 0 in that cycle.
- `rst` asserted mid-operation discards all queued messages. `valid` is 0 in the cycle after the reset edge.

## Configuration
- `POLY3_SOURCE_STATS_EN` defined:
  - Port `sent` exists: 16-bit count of completed handshakes.
  - Increments on every pop, wraps 0xFFFF→0, resets to 0.
- Not defined: the `sent` port and its counter are absent. All other behaviour is identical.

## Test plan
- Write a=42, b=184, c=2, then commit with `ready`=1. Required: one cycle later `valid`=1 with data {42,184,2}. It pops on that edge; `count` returns to 0 and `valid` drops next cycle.
- Hold `ready`=0 and commit 4 distinct triples, c=1..4.
  - Required: `count`=4, `full`=1, and `data` stays at c=1 throughout.
  - Then raise `ready`. Required: c=1,2,3,4 emerge on four consecutive cycles.
- With the FIFO full and `ready`=0, commit c=5. Required: `overflow`=1, `count`=4. Draining yields c=1..4 only.
- With the FIFO full, commit c=9 in the same cycle `ready`=1. Required: accepted, `count` stays 4, `overflow` stays 0, and c=9 emerges last.
- With `ready`=0 and 3 queued, assert `rst` for one cycle. Required: `valid`=0, `count`=0, `overflow`=0, staging registers=0.
- `POLY3_SOURCE_STATS_EN` build: run 65537 handshakes. Required: `sent`=1.
